// File: rtl/dstack_pkg.sv
// dstack_pkg
//   Shared definitions for the data stack and the stack-control block that
//   drives it. Both sides import the movement encoding from here, so the
//   2-bit movement bus means the same thing on each end.
//   Contents:
//     dstack_move_t  movement encoding (none / push / pop 1 / pop 2)
//     ROT_ADDR_W     width of the rotate / copy depth index
package dstack_pkg;

  typedef enum logic [1:0] {
    MOVE_NONE = 2'b00,
    MOVE_PUSH = 2'b01,
    MOVE_POP1 = 2'b10,
    MOVE_POP2 = 2'b11
  } dstack_move_t;

  localparam int ROT_ADDR_W = 5;

endpackage : dstack_pkg

// File: rtl/dstack_regfile.sv
// dstack_regfile
//   Registered shift-register data stack. Each clock edge, entry 0 always
//   takes next_top. The rest of the stack shifts according to movement or
//   rotate. Depth is tracked alongside the data, with sticky overflow and
//   underflow flags.
//   Ports:
//     clk, reset    rising-edge clock, synchronous active-high reset
//     movement      00 none, 01 push, 10 pop 1, 11 pop 2
//     next_top      value loaded into entry 0 on every edge
//     rotate        bring entry rotate_addr to the top (overrides movement)
//     rotate_addr   depth index used by rotate and by copy reads (0 = top)
//     top/second/third  entries 0..2, registered
//     rotate_value  entry[rotate_addr], combinational
//     depth         number of valid entries, registered
//     overflow      sticky: push attempted while full
//     underflow     sticky: pop past empty, or read beyond valid entries
//   DEPTH must be at least 32 so that every rotate_addr value is in range.
module dstack_regfile
  import dstack_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 movement,
  input  logic [WORD_WIDTH-1:0]      next_top,
  input  logic                       rotate,
  input  logic [ROT_ADDR_W-1:0]      rotate_addr,
  output logic [WORD_WIDTH-1:0]      top,
  output logic [WORD_WIDTH-1:0]      second,
  output logic [WORD_WIDTH-1:0]      third,
  output logic [WORD_WIDTH-1:0]      rotate_value,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  dstack_move_t move;
  assign move = dstack_move_t'(movement);

  logic [WORD_WIDTH-1:0] e_reg  [DEPTH];
  logic [WORD_WIDTH-1:0] e_next [DEPTH];

  logic [DW-1:0] depth_reg, depth_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;

  // Per-entry next-value select. Entry 0 is always next_top. Deeper
  // entries take the neighbour above (push/rotate), a neighbour below
  // (pops), or hold. A pop removes entries from the logical stack:
  // pop 1 drops one entry, so e[i] takes e[i+1]; pop 2 drops two, so
  // e[i] takes e[i+2]. Positions shifted in from past the bottom are
  // zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    if (gi == 0) begin : g_top
      assign e_next[gi] = next_top;
    end else begin : g_body
      logic [WORD_WIDTH-1:0] below1;
      logic [WORD_WIDTH-1:0] below2;
      logic [WORD_WIDTH-1:0] nxt;

      if (gi + 1 < DEPTH) begin : g_b1
        assign below1 = e_reg[gi+1];
      end else begin : g_b1_zero
        assign below1 = '0;
      end

      if (gi + 2 < DEPTH) begin : g_b2
        assign below2 = e_reg[gi+2];
      end else begin : g_b2_zero
        assign below2 = '0;
      end

      always_comb begin
        nxt = e_reg[gi];
        if (rotate) begin
          // Entries 1..rotate_addr slide down one slot to make room for
          // the rotated value, which arrives at the top via next_top.
          if (32'(gi) <= 32'(rotate_addr)) begin
            nxt = e_reg[gi-1];
          end
        end else begin
          unique case (move)
            MOVE_NONE: nxt = e_reg[gi];
            MOVE_PUSH: nxt = e_reg[gi-1];
            MOVE_POP1: nxt = below1;
            MOVE_POP2: nxt = below2;
            default:   nxt = e_reg[gi];
          endcase
        end
      end

      assign e_next[gi] = nxt;
    end
  end

  // An access to entry 0 never counts as reading past the valid entries.
  // A plain literal push into an empty stack presents rotate_addr==0,
  // and that must not raise underflow.
  logic addr_oob;
  assign addr_oob = (rotate_addr != '0) && (DW'(rotate_addr) >= depth_reg);

  always_comb begin
    depth_next     = depth_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (rotate) begin
      if (addr_oob) underflow_next = 1'b1;
    end else begin
      unique case (move)
        MOVE_NONE: ;
        MOVE_PUSH: begin
          if (addr_oob) underflow_next = 1'b1;
          if (depth_reg == DW'(DEPTH)) begin
            overflow_next = 1'b1;
          end else begin
            depth_next = depth_reg + DW'(1);
          end
        end
        MOVE_POP1: begin
          if (depth_reg == '0) begin
            underflow_next = 1'b1;
          end else begin
            depth_next = depth_reg - DW'(1);
          end
        end
        MOVE_POP2: begin
          if (depth_reg < DW'(2)) begin
            underflow_next = 1'b1;
            depth_next     = '0;
          end else begin
            depth_next = depth_reg - DW'(2);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        e_reg[i] <= '0;
      end
      depth_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        e_reg[i] <= e_next[i];
      end
      depth_reg     <= depth_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign top          = e_reg[0];
  assign second       = e_reg[1];
  assign third        = e_reg[2];
  assign rotate_value = e_reg[AW'(rotate_addr)];
  assign depth        = depth_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule : dstack_regfile

// File: tb/tb_dstack_regfile.sv
// tb_dstack_regfile
//   Directed bench for dstack_regfile. Every clocked step pushes its
//   expected post-edge state into a scoreboard queue. After the edge, the
//   entry is popped and compared against the DUT outputs.
//   Combinational rotate_value reads are compared directly.
module tb_dstack_regfile;
  import dstack_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 64;
  localparam int DW    = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [1:0]            movement;
  logic [W-1:0]          next_top;
  logic                  rotate;
  logic [ROT_ADDR_W-1:0] rotate_addr;
  logic [W-1:0]          top, second, third, rotate_value;
  logic [DW-1:0]         depth;
  logic                  overflow, underflow;

  dstack_regfile #(.WORD_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .movement     (movement),
    .next_top     (next_top),
    .rotate       (rotate),
    .rotate_addr  (rotate_addr),
    .top          (top),
    .second       (second),
    .third        (third),
    .rotate_value (rotate_value),
    .depth        (depth),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] top;
    logic [W-1:0] second;
    logic [W-1:0] third;
    int           depth;
    logic         ovf;
    logic         udf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      $error("check %s differs", tag);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] mv, input logic [W-1:0] nt,
                       input logic rot, input logic [ROT_ADDR_W-1:0] ra);
    reset       = rst;
    movement    = mv;
    next_top    = nt;
    rotate      = rot;
    rotate_addr = ra;
    @(posedge clk);
    #1;
  endtask

  // Clocked step whose expected result goes through the scoreboard.
  task automatic step_chk(input logic rst, input logic [1:0] mv, input logic [W-1:0] nt,
                          input logic rot, input logic [ROT_ADDR_W-1:0] ra,
                          input exp_t e);
    exp_t got;
    sb.push_back(e);
    drive(rst, mv, nt, rot, ra);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard empty", e.tag);
    end else begin
      got = sb.pop_front();
      cmp({got.tag, ".top"},    top,                   got.top);
      cmp({got.tag, ".second"}, second,                got.second);
      cmp({got.tag, ".third"},  third,                 got.third);
      cmp({got.tag, ".depth"},  W'(depth),             W'(got.depth));
      cmp({got.tag, ".ovf"},    W'(overflow),          W'(got.ovf));
      cmp({got.tag, ".udf"},    W'(underflow),         W'(got.udf));
      $display("step %s: top=%0d second=%0d third=%0d depth=%0d ovf=%0b udf=%0b",
               got.tag, top, second, third, depth, overflow, underflow);
    end
  endtask

  task automatic check_rv(input string tag, input logic [ROT_ADDR_W-1:0] ra, input logic [W-1:0] expv);
    rotate_addr = ra;
    #1;
    cmp(tag, rotate_value, expv);
    $display("read %s: addr=%0d value=%0d", tag, ra, rotate_value);
  endtask

  localparam logic [1:0] MV_NONE = 2'b00;
  localparam logic [1:0] MV_PUSH = 2'b01;
  localparam logic [1:0] MV_POP1 = 2'b10;
  localparam logic [1:0] MV_POP2 = 2'b11;

  initial begin
    reset = 1'b1; movement = MV_NONE; next_top = '0; rotate = 1'b0; rotate_addr = '0;
    drive(1'b1, MV_NONE, 0, 1'b0, 0);

    // reset state
    step_chk(1'b1, MV_NONE, 0, 1'b0, 0, '{"reset", 0, 0, 0, 0, 1'b0, 1'b0});

    // 1: push 1,2,3
    drive(1'b0, MV_PUSH, 1, 1'b0, 0);
    drive(1'b0, MV_PUSH, 2, 1'b0, 0);
    step_chk(1'b0, MV_PUSH, 3, 1'b0, 0, '{"t1_push3", 3, 2, 1, 3, 1'b0, 1'b0});

    // 2: pop1, pop2 to empty, then pop2 past empty
    step_chk(1'b0, MV_POP1, 2, 1'b0, 0, '{"t2_pop1", 2, 1, 0, 2, 1'b0, 1'b0});
    step_chk(1'b0, MV_POP2, 0, 1'b0, 0, '{"t2_pop2", 0, 0, 0, 0, 1'b0, 1'b0});
    step_chk(1'b0, MV_POP2, 0, 1'b0, 0, '{"t2_pop2_empty", 0, 0, 0, 0, 1'b0, 1'b1});

    // 3: push 10,20,30,40 then rotate entry 3 to the top
    drive(1'b0, MV_PUSH, 10, 1'b0, 0);
    drive(1'b0, MV_PUSH, 20, 1'b0, 0);
    drive(1'b0, MV_PUSH, 30, 1'b0, 0);
    step_chk(1'b0, MV_PUSH, 40, 1'b0, 0, '{"t3_push4", 40, 30, 20, 4, 1'b0, 1'b1});
    check_rv("t3_rv_before", 3, 10);
    step_chk(1'b0, MV_NONE, 10, 1'b1, 3, '{"t3_rotate", 10, 40, 30, 4, 1'b0, 1'b1});
    check_rv("t3_rv_e3", 3, 20);

    // 4: push DEPTH+1 values 1..DEPTH+1
    for (int v = 1; v <= DEPTH; v++) begin
      drive(1'b0, MV_PUSH, W'(v), 1'b0, 0);
    end
    step_chk(1'b0, MV_PUSH, W'(DEPTH + 1), 1'b0, 0,
             '{"t4_full", W'(DEPTH + 1), W'(DEPTH), W'(DEPTH - 1), DEPTH, 1'b1, 1'b1});
    cmp("t4_bottom", dut.e_reg[DEPTH-1], 2);
    check_rv("t4_rv31", 31, W'(DEPTH + 1 - 31));

    // 5: copy from depth 2, then copy from beyond the valid entries
    step_chk(1'b1, MV_NONE, 0, 1'b0, 0, '{"t5_reset", 0, 0, 0, 0, 1'b0, 1'b0});
    drive(1'b0, MV_PUSH, 9, 1'b0, 0);
    step_chk(1'b0, MV_PUSH, 7, 1'b0, 0, '{"t5_setup", 7, 9, 0, 2, 1'b0, 1'b0});
    check_rv("t5_rv1", 1, 9);
    step_chk(1'b0, MV_PUSH, 9, 1'b0, 1, '{"t5_copy1", 9, 7, 9, 3, 1'b0, 1'b0});
    check_rv("t5_rv5", 5, 0);
    step_chk(1'b0, MV_PUSH, 0, 1'b0, 5, '{"t5_copy5", 0, 9, 7, 4, 1'b0, 1'b1});

    // 6: reset wins over a push in the same cycle
    step_chk(1'b1, MV_PUSH, 55, 1'b0, 0, '{"t6_reset_push", 0, 0, 0, 0, 1'b0, 1'b0});
    check_rv("t6_rv0", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // rotate must never be combined with a movement.
  always @(posedge clk) begin
    if (reset === 1'b0 && rotate === 1'b1) begin
      assert (movement == MV_NONE) else $error("rotate presented with movement %0b", movement);
    end
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "bench did not finish");
  end

endmodule : tb_dstack_regfile
